// File: rtl/board_row_streamer.sv
// rtl/board_row_streamer.sv - 20x10 playfield store that streams dirty rows to the renderer
// One row may be emitted per cycle; the scan pointer visits every row in turn.
module board_row_streamer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic [4:0]  wrRow,
  input  logic [3:0]  wrCol,
  input  logic [2:0]  wrColor,
  input  logic        clrAll,
  input  logic        refresh,
  input  logic        hold,
  output logic [4:0]  index,
  output logic [29:0] oData,
  output logic        busy
);

  localparam logic [4:0] IDLE_IDX = 5'h1F;
  localparam logic [4:0] LAST_ROW = 5'd19;

  logic [29:0] r_board [0:19];
  logic [19:0] r_dirty;
  logic [4:0]  r_ptr;
  logic [4:0]  r_index;
  logic [29:0] r_odata;

  logic        w_wr_ok;
  logic [4:0]  w_wr_row;
  logic        w_emit;
  logic [29:0] w_row_new;
  logic [19:0] w_dirty_nxt;

  // clrAll discards a simultaneous write
  assign w_wr_ok  = wrEn && (wrRow < 5'd20) && (wrCol < 4'd10) && !clrAll;
  assign w_wr_row = (wrRow < 5'd20) ? wrRow : 5'd0;
  assign w_emit   = !hold && r_dirty[r_ptr];

  always_comb begin
    w_row_new = r_board[w_wr_row];
    for (int c = 0; c < 10; c++) begin
      if (wrCol == 4'(c)) w_row_new[29-3*c -: 3] = wrColor;
    end
  end

  // A write or global mark landing on the emitted row keeps it dirty
  always_comb begin
    w_dirty_nxt = r_dirty;
    if (w_emit) w_dirty_nxt[r_ptr] = 1'b0;
    if (w_wr_ok) w_dirty_nxt[w_wr_row] = 1'b1;
    if (clrAll || refresh) w_dirty_nxt = '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 20; r++) r_board[r] <= '0;
      r_dirty <= '1;
      r_ptr   <= '0;
      r_index <= IDLE_IDX;
      r_odata <= '0;
    end else begin
      if (clrAll) begin
        for (int r = 0; r < 20; r++) r_board[r] <= '0;
      end else if (w_wr_ok) begin
        r_board[w_wr_row] <= w_row_new;
      end
      r_dirty <= w_dirty_nxt;
      if (w_emit) begin
        r_index <= r_ptr;
        r_odata <= r_board[r_ptr];
      end else begin
        r_index <= IDLE_IDX;
      end
      if (!hold) r_ptr <= (r_ptr == LAST_ROW) ? 5'd0 : r_ptr + 5'd1;
    end
  end

  assign index = r_index;
  assign oData = r_odata;
  assign busy  = |r_dirty;

endmodule

// File: tb/tb_board_row_streamer.sv
// tb/tb_board_row_streamer.sv - randomized and directed checks against a playfield model
module tb_board_row_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrEn = 1'b0;
  logic [4:0]  wrRow = '0;
  logic [3:0]  wrCol = '0;
  logic [2:0]  wrColor = '0;
  logic        clrAll = 1'b0;
  logic        refresh = 1'b0;
  logic        hold = 1'b0;
  logic [4:0]  index;
  logic [29:0] oData;
  logic        busy;

  int vectors = 0;
  int errors = 0;

  // Model: cell grid, set of rows still owed to the renderer, scan position
  int          m_cell [20][10];
  bit          m_owed [20];
  int          m_ptr;
  logic [4:0]  e_index;
  logic [29:0] e_data;

  board_row_streamer dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrRow(wrRow), .wrCol(wrCol),
    .wrColor(wrColor), .clrAll(clrAll), .refresh(refresh), .hold(hold),
    .index(index), .oData(oData), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] row_value(int r);
    logic [29:0] v = '0;
    for (int c = 0; c < 10; c++) v = v | (30'(m_cell[r][c]) << (27 - 3 * c));
    return v;
  endfunction

  function automatic bit any_owed();
    for (int r = 0; r < 20; r++) if (m_owed[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 20; r++) begin
      m_owed[r] = 1'b1;
      for (int c = 0; c < 10; c++) m_cell[r][c] = 0;
    end
    m_ptr = 0;
    e_index = 5'h1F;
    e_data = '0;
  endtask

  task automatic clear_inputs();
    wrEn = 0; clrAll = 0; refresh = 0; hold = 0;
  endtask

  // Advance one clock: predict from the pre-edge model, then compare all outputs.
  task automatic cycle();
    bit sent;
    bit legal;
    sent = !hold && m_owed[m_ptr];
    legal = wrEn && wrRow < 20 && wrCol < 10 && !clrAll;
    e_index = 5'h1F;
    if (sent) begin
      e_index = 5'(m_ptr);
      e_data = row_value(m_ptr);
      m_owed[m_ptr] = 1'b0;
    end
    if (clrAll) begin
      for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) m_cell[r][c] = 0;
    end
    if (legal) begin
      m_cell[wrRow][wrCol] = int'(wrColor);
      m_owed[wrRow] = 1'b1;
    end
    if (clrAll || refresh) for (int r = 0; r < 20; r++) m_owed[r] = 1'b1;
    if (!hold) m_ptr = (m_ptr + 1) % 20;
    @(posedge clk);
    #1;
    vectors++;
    if (index !== e_index || oData !== e_data || busy !== any_owed()) begin
      errors++;
      $display("FAIL cycle: index=%h oData=%h busy=%b expected index=%h oData=%h busy=%b",
               index, oData, busy, e_index, e_data, any_owed());
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 25; i++) cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    model_reset();
    #12;
    vectors++;
    if (index !== 5'h1F || oData !== 30'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: index=%h oData=%h busy=%b expected 1f 0 1", index, oData, busy);
    end
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      vectors++;
      if (index !== 5'(i) || oData !== 30'h0) begin
        errors++;
        $display("FAIL reset_sweep: index=%0d oData=%h expected %0d 0", index, oData, i);
      end
    end
    for (int i = 0; i < 5; i++) cycle();
    vectors++;
    if (busy !== 1'b0 || index !== 5'h1F) begin
      errors++;
      $display("FAIL reset_idle: busy=%b index=%h expected 0 1f", busy, index);
    end
  endtask

  task automatic single_write(input int row, input int col, input int color,
                              input logic [29:0] want, input string name);
    int seen = 0;
    wrEn = 1; wrRow = 5'(row); wrCol = 4'(col); wrColor = 3'(color);
    cycle();
    wrEn = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (index != 5'h1F) begin
        seen++;
        vectors++;
        if (index !== 5'(row) || oData !== want) begin
          errors++;
          $display("FAIL %s: index=%0d oData=%h expected %0d %h", name, index, oData, row, want);
        end
      end
    end
    vectors++;
    if (seen != 1) begin
      errors++;
      $display("FAIL %s_count: emissions=%0d expected 1", name, seen);
    end
  endtask

  task automatic test_col0_write();
    single_write(5, 0, 2, 30'h1000_0000, "col0_write");
  endtask

  task automatic test_col9_write();
    single_write(19, 9, 1, 30'h0000_0001, "col9_write");
  endtask

  task automatic test_out_of_range();
    wrEn = 1; wrRow = 5'd20; wrCol = 4'd3; wrColor = 3'd1;
    cycle();
    wrRow = 5'd4; wrCol = 4'd12;
    cycle();
    wrEn = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      vectors++;
      if (index !== 5'h1F || busy !== 1'b0) begin
        errors++;
        $display("FAIL out_of_range: index=%h busy=%b expected 1f 0", index, busy);
      end
    end
  endtask

  task automatic test_collision();
    logic [29:0] old_row;
    refresh = 1;
    cycle();
    refresh = 0;
    for (int i = 0; i < 40 && m_ptr != 7; i++) cycle();
    old_row = row_value(7);
    wrEn = 1; wrRow = 5'd7; wrCol = 4'd0; wrColor = 3'd1;
    cycle();
    wrEn = 0;
    vectors++;
    if (index !== 5'd7 || oData !== old_row) begin
      errors++;
      $display("FAIL collision_first: index=%0d oData=%h expected 7 %h", index, oData, old_row);
    end
    for (int i = 0; i < 20; i++) cycle();
    vectors++;
    if (index !== 5'd7 || oData !== 30'h0800_0000) begin
      errors++;
      $display("FAIL collision_second: index=%0d oData=%h expected 7 08000000", index, oData);
    end
    settle();
  endtask

  task automatic test_hold_clr();
    int start;
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      clrAll = (i == 3);
      cycle();
      vectors++;
      if (index !== 5'h1F) begin
        errors++;
        $display("FAIL hold_idle: index=%h expected 1f", index);
      end
    end
    clrAll = 0;
    hold = 0;
    start = m_ptr;
    for (int i = 0; i < 20; i++) begin
      cycle();
      vectors++;
      if (index !== 5'((start + i) % 20) || oData !== 30'h0) begin
        errors++;
        $display("FAIL hold_release: index=%0d oData=%h expected %0d 0", index, oData, (start + i) % 20);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wrEn = ($urandom_range(0, 2) != 0);
      wrRow = 5'($urandom_range(0, 22));
      wrCol = 4'($urandom_range(0, 11));
      wrColor = 3'($urandom);
      clrAll = ($urandom_range(0, 60) == 0);
      refresh = ($urandom_range(0, 40) == 0);
      hold = ($urandom_range(0, 4) == 0);
      cycle();
    end
    clear_inputs();
    settle();
  endtask

  task automatic test_midreset();
    wrEn = 1; wrRow = 5'd2; wrCol = 4'd4; wrColor = 3'd3;
    cycle();
    wrEn = 0;
    refresh = 1;
    cycle();
    refresh = 0;
    for (int i = 0; i < 6; i++) cycle();
    rst = 0;
    #1;
    model_reset();
    vectors++;
    if (index !== 5'h1F || oData !== 30'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: index=%h oData=%h busy=%b expected 1f 0 1", index, oData, busy);
    end
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      vectors++;
      if (index !== 5'(i) || oData !== 30'h0) begin
        errors++;
        $display("FAIL midreset_sweep: index=%0d oData=%h expected %0d 0", index, oData, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_col0_write();
    test_col9_write();
    test_out_of_range();
    test_collision();
    test_hold_clr();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
